// File: rtl/window_buffer_if.sv
// Handshake and window bus between the element source, window_buffer and the
// window consumer. clr travels with the bus because the source drives it.
interface window_buffer_if #(
  parameter int DATA_W = 8,
  parameter int ROWS   = 4,
  parameter int COLS   = 4
);
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;

  logic                          clr;
  logic                          in_valid;
  logic                          in_ready;
  logic [DATA_W-1:0]             data_in;
  logic                          out_valid;
  logic                          out_ready;
  logic                          slide;
  logic [ROWS*COLS*DATA_W-1:0]   data_out;
  logic [RW-1:0]                 fill_row;
  logic [CW-1:0]                 fill_col;

  modport slave (
    input  clr, in_valid, data_in, out_ready, slide,
    output in_ready, out_valid, data_out, fill_row, fill_col
  );

  modport master (
    output clr, in_valid, data_in, out_ready, slide,
    input  in_ready, out_valid, data_out, fill_row, fill_col
  );
endinterface

// File: rtl/window_buffer.sv
// ROWS x COLS window buffer: fills row-major, then holds the window until released.
// Define WINDOW_BUFFER_SLIDE_EN to enable slide releases (shift left, refill last column).
module window_buffer #(
  parameter int DATA_W = 8,
  parameter int ROWS   = 4,
  parameter int COLS   = 4
) (
  input  logic              clk,
  input  logic              rst,
  window_buffer_if.slave    bus
);
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);

  typedef enum logic {FILL = 1'b0, FULL = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [RW-1:0]     row_q, row_d;
  logic [CW-1:0]     col_q, col_d;
  logic              wr_en;
  logic              slide_mode;
  logic [DATA_W-1:0] win [ROWS][COLS];

`ifdef WINDOW_BUFFER_SLIDE_EN
  logic slide_rel;
  logic slm_d;

  // Remembers that the current fill only targets the last column.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) slide_mode <= 1'b0;
    else     slide_mode <= slm_d;
  end
`else
  logic unused_slide;
  assign unused_slide = bus.slide;
  assign slide_mode   = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FILL;
      row_q   <= '0;
      col_q   <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
    end
  end

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    wr_en   = 1'b0;
`ifdef WINDOW_BUFFER_SLIDE_EN
    slide_rel = 1'b0;
    slm_d     = slide_mode;
`endif
    if (bus.clr) begin
      state_d = FILL;
      row_d   = '0;
      col_d   = '0;
`ifdef WINDOW_BUFFER_SLIDE_EN
      slm_d   = 1'b0;
`endif
    end else begin
      unique case (state_q)
        FILL: begin
          if (bus.in_valid) begin
            wr_en = 1'b1;
            if (slide_mode) begin
              if (row_q == ROW_LAST) begin
                state_d = FULL;
                row_d   = '0;
                col_d   = '0;
              end else begin
                row_d = row_q + 1'b1;
              end
            end else if (col_q == COL_LAST) begin
              col_d = '0;
              if (row_q == ROW_LAST) begin
                state_d = FULL;
                row_d   = '0;
              end else begin
                row_d = row_q + 1'b1;
              end
            end else begin
              col_d = col_q + 1'b1;
            end
          end
        end
        FULL: begin
          if (bus.out_ready) begin
            state_d = FILL;
            row_d   = '0;
            col_d   = '0;
`ifdef WINDOW_BUFFER_SLIDE_EN
            if (bus.slide) begin
              slide_rel = 1'b1;
              col_d     = COL_LAST;
              slm_d     = 1'b1;
            end else begin
              slm_d     = 1'b0;
            end
`endif
          end
        end
        default: state_d = FILL;
      endcase
    end
  end

  // Storage is written only by a handshake, a slide release or a clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++)
          win[r][c] <= '0;
    end else if (bus.clr) begin
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++)
          win[r][c] <= '0;
`ifdef WINDOW_BUFFER_SLIDE_EN
    end else if (slide_rel) begin
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < COLS - 1; c++)
          win[r][c] <= win[r][c+1];
        win[r][COLS-1] <= '0;
      end
`endif
    end else if (wr_en) begin
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++)
          if (row_q == RW'(r) && col_q == CW'(c))
            win[r][c] <= bus.data_in;
    end
  end

  assign bus.in_ready  = (state_q == FILL);
  assign bus.out_valid = (state_q == FULL);
  assign bus.fill_row  = row_q;
  assign bus.fill_col  = col_q;

  // Element (0,0) lands in the most significant slot.
  for (genvar gr = 0; gr < ROWS; gr++) begin : g_row
    for (genvar gc = 0; gc < COLS; gc++) begin : g_col
      assign bus.data_out[(ROWS*COLS-1-(gr*COLS+gc))*DATA_W +: DATA_W] = win[gr][gc];
    end
  end
endmodule

// File: tb/tb_window_buffer.sv
// Bench for window_buffer: directed scenarios plus randomized traffic against
// a write-count based reference model.
module tb_window_buffer;
  localparam int DATA_W = 8;
  localparam int ROWS   = 2;
  localparam int COLS   = 3;
  localparam int N      = ROWS * COLS;
  localparam int W      = N * DATA_W;
`ifdef WINDOW_BUFFER_SLIDE_EN
  localparam bit SLIDE_EN = 1'b1;
`else
  localparam bit SLIDE_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  window_buffer_if #(.DATA_W(DATA_W), .ROWS(ROWS), .COLS(COLS)) bus();

  window_buffer #(.DATA_W(DATA_W), .ROWS(ROWS), .COLS(COLS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Reference model: window contents plus number of writes into the current window.
  logic [DATA_W-1:0] m_win [ROWS][COLS];
  int                m_cnt;
  bit                m_full;
  bit                m_smode;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [W-1:0] m_pack();
    logic [W-1:0] v;
    v = '0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        v[(N-1-(r*COLS+c))*DATA_W +: DATA_W] = m_win[r][c];
    return v;
  endfunction

  task automatic m_reset();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        m_win[r][c] = '0;
    m_cnt   = 0;
    m_full  = 1'b0;
    m_smode = 1'b0;
  endtask

  task automatic m_step();
    if (bus.clr) begin
      m_reset();
    end else if (!m_full) begin
      if (bus.in_valid) begin
        if (m_smode) m_win[m_cnt][COLS-1] = bus.data_in;
        else         m_win[m_cnt / COLS][m_cnt % COLS] = bus.data_in;
        m_cnt++;
        if (m_cnt == (m_smode ? ROWS : N)) m_full = 1'b1;
      end
    end else if (bus.out_ready) begin
      m_full = 1'b0;
      m_cnt  = 0;
      if (SLIDE_EN && bus.slide) begin
        for (int r = 0; r < ROWS; r++) begin
          for (int c = 0; c < COLS - 1; c++)
            m_win[r][c] = m_win[r][c+1];
          m_win[r][COLS-1] = '0;
        end
        m_smode = 1'b1;
      end else begin
        m_smode = 1'b0;
      end
    end
  endtask

  task automatic check_all(input string ph);
    chk({ph, ".data"}, 64'(bus.data_out), 64'(m_pack()));
    chk({ph, ".ovld"}, 64'(bus.out_valid), 64'(m_full));
    chk({ph, ".irdy"}, 64'(bus.in_ready), 64'(!m_full));
    if (!m_full) begin
      chk({ph, ".row"}, 64'(bus.fill_row), 64'(m_smode ? m_cnt : m_cnt / COLS));
      chk({ph, ".col"}, 64'(bus.fill_col), 64'(m_smode ? COLS - 1 : m_cnt % COLS));
    end
  endtask

  task automatic cyc(input string ph);
    m_step();
    @(posedge clk);
    #1;
    check_all(ph);
  endtask

  task automatic idle_inputs();
    bus.clr       = 1'b0;
    bus.in_valid  = 1'b0;
    bus.data_in   = '0;
    bus.out_ready = 1'b0;
    bus.slide     = 1'b0;
  endtask

  task automatic wr(input logic [DATA_W-1:0] d, input string ph);
    bus.in_valid = 1'b1;
    bus.data_in  = d;
    cyc(ph);
    bus.in_valid = 1'b0;
  endtask

  task automatic fill_seq(input string ph);
    for (int i = 0; i < N; i++) wr(8'(8'h11 * (i + 1)), ph);
  endtask

  // Called just after an edge: raises rst between edges and checks it acts at once.
  task automatic async_reset(input string ph);
    #3 rst = 1'b1;
    #1;
    chk({ph, ".data"}, 64'(bus.data_out), 64'h0);
    chk({ph, ".ovld"}, 64'(bus.out_valid), 64'h0);
    chk({ph, ".irdy"}, 64'(bus.in_ready), 64'h1);
    chk({ph, ".row"},  64'(bus.fill_row), 64'h0);
    chk({ph, ".col"},  64'(bus.fill_col), 64'h0);
    m_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_all({ph, ".after"});
  endtask

  initial begin
    idle_inputs();
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset.data", 64'(bus.data_out), 64'h0);
    chk("reset.ovld", 64'(bus.out_valid), 64'h0);
    chk("reset.irdy", 64'(bus.in_ready), 64'h1);
    check_all("reset");

    wr(8'h11, "pre");
    wr(8'h22, "pre");
    async_reset("rst_mid");

    fill_seq("fill");
    chk("fill.ovld", 64'(bus.out_valid), 64'h1);
    chk("fill.irdy", 64'(bus.in_ready), 64'h0);
    chk("fill.data", 64'(bus.data_out), 64'h112233445566);

    bus.in_valid = 1'b1;
    bus.data_in  = 8'h77;
    for (int i = 0; i < 5; i++) begin
      cyc("bp");
      chk("bp.data", 64'(bus.data_out), 64'h112233445566);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    cyc("rel");
    chk("rel.ovld", 64'(bus.out_valid), 64'h0);
    chk("rel.irdy", 64'(bus.in_ready), 64'h1);
    chk("rel.row",  64'(bus.fill_row), 64'h0);
    chk("rel.col",  64'(bus.fill_col), 64'h0);
    chk("rel.data", 64'(bus.data_out), 64'h112233445566);
    idle_inputs();

    wr(8'hA1, "gap");
    repeat (3) cyc("gap.idle");
    wr(8'hA2, "gap");
    chk("gap.row", 64'(bus.fill_row), 64'h0);
    chk("gap.col", 64'(bus.fill_col), 64'h2);
    bus.clr      = 1'b1;
    bus.in_valid = 1'b1;
    bus.data_in  = 8'hA3;
    cyc("clr");
    chk("clr.data", 64'(bus.data_out), 64'h0);
    chk("clr.row",  64'(bus.fill_row), 64'h0);
    chk("clr.col",  64'(bus.fill_col), 64'h0);
    idle_inputs();

    fill_seq("refill");
    bus.out_ready = 1'b1;
    bus.slide     = 1'b1;
    cyc("slide");
    idle_inputs();
`ifdef WINDOW_BUFFER_SLIDE_EN
    chk("slide.data", 64'(bus.data_out), 64'h223300556600);
    chk("slide.row",  64'(bus.fill_row), 64'h0);
    chk("slide.col",  64'(bus.fill_col), 64'h2);
    wr(8'hAA, "slide.wr");
    wr(8'hBB, "slide.wr");
    chk("slide.ovld", 64'(bus.out_valid), 64'h1);
    chk("slide.win",  64'(bus.data_out), 64'h2233AA5566BB);
`else
    chk("noslide.row",  64'(bus.fill_row), 64'h0);
    chk("noslide.col",  64'(bus.fill_col), 64'h0);
    chk("noslide.data", 64'(bus.data_out), 64'h112233445566);
    wr(8'hAA, "noslide.wr");
    wr(8'hBB, "noslide.wr");
    chk("noslide.early", 64'(bus.out_valid), 64'h0);
    for (int i = 0; i < N - 2; i++) wr(8'(8'hC0 + i), "noslide.wr");
    chk("noslide.ovld", 64'(bus.out_valid), 64'h1);
`endif

    for (int i = 0; i < 3000; i++) begin
      bus.clr       = ($urandom_range(0, 39) == 0);
      bus.in_valid  = ($urandom_range(0, 9) < 7);
      bus.data_in   = 8'($urandom);
      bus.out_ready = 1'($urandom);
      bus.slide     = 1'($urandom);
      cyc("rand");
      if ($urandom_range(0, 399) == 0) async_reset("rand_rst");
    end
    idle_inputs();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/window_buffer.md
# window_buffer

Parametrised 2-D window buffer. It collects a stream of DATA_W-bit elements into a ROWS x COLS register array through a valid/ready handshake, then presents the whole window as one flat vector with a valid/ready handshake on the output side. It sits between the element source (memory reader) and the window-consuming datapath (multiply/accumulate stage). An optional slide mode refills only the last column, so that overlapping windows stream with ROWS writes per window instead of ROWS*COLS.

## Interface
Parameters:
- DATA_W, 8, element width in bits (≥1)
- ROWS, 4, window rows (≥1)
- COLS, 4, window columns (≥2)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- clr  in  1  synchronous clear
- in_valid  in  1  data_in valid
- in_ready  out  1  buffer accepts data_in
- data_in  in  DATA_W  element to write
- out_valid  out  1  window complete
- out_ready  in  1  consumer accepts the window
- slide  in  1  on window release, shift instead of refill; only effective with the macro
- data_out  out  ROWS*COLS*DATA_W  flattened window
- fill_row  out  max(1,clog2(ROWS))  row of the next write
- fill_col  out  max(1,clog2(COLS))  column of the next write

## Operation
- Storage: buf[r][c]. data_out places element (r,c) at bits [(ROWS*COLS-1-(r*COLS+c))*DATA_W +: DATA_W], so (0,0) occupies the MSBs.
- The FSM has two states, FILL and FULL. in_ready = (state==FILL) and out_valid = (state==FULL); both are decoded from registered state only.
- FILL, full mode: each accepted write (in_valid & in_ready) stores data_in at (fill_row, fill_col).
  - The pointer advances row-major: col+1; at col==COLS-1 it wraps to 0 and row advances.
  - The write at (ROWS-1, COLS-1) moves the FSM to FULL.
- FULL: in_valid is ignored and storage is frozen.
  - out_valid & out_ready (slide=0): FSM goes to FILL, pointer resets to (0,0).
  - Storage is retained and overwritten element by element during the next fill.
- clr has priority over all handshakes. It zeroes storage, resets the pointer to (0,0) and sets state to FILL. A write in the same cycle is dropped.
- rst asserts the same values as clr, asynchronously, and may do so at any point, including mid-fill or while FULL.
- Reset values: data_out=0, out_valid=0, in_ready=1, fill_row=0, fill_col=0.

## Timing
- A write is captured on the clock edge where in_valid & in_ready. data_out shows the new element the following cycle.
- out_valid rises in the cycle after the final write, and in_ready falls in that same cycle.
- A release is taken on the edge where out_valid & out_ready. In the next cycle out_valid=0 and in_ready=1.
- Minimum window period: ROWS*COLS+1 cycles in full mode, ROWS+1 cycles in slide mode.
- Bubbles on in_valid stall the pointer without any other effect.

## Configuration
- WINDOW_BUFFER_SLIDE_EN defined: a release with slide=1 does the following in one edge:
  - shifts every row left by one column (buf[r][c] ← buf[r][c+1]);
  - zeroes column COLS-1;
  - sets the pointer to (0, COLS-1).
- Slide-mode fill then writes column COLS-1 only, row by row. The write at row ROWS-1 moves the FSM to FULL.
- WINDOW_BUFFER_SLIDE_EN undefined: the slide port is present but ignored, and every release is a full refill. No shift logic is synthesised.

## Test plan
All scenarios use DATA_W=8, ROWS=2, COLS=3.
- Reset: assert rst mid-fill -> data_out=0, out_valid=0, in_ready=1, pointer (0,0).
- Full fill: write 0x11..0x66 back-to-back -> out_valid=1 and in_ready=0 the cycle after the sixth write; data_out=48'h112233445566.
- Backpressure: hold out_ready=0 for 5 cycles with in_valid=1 and data 0x77 -> data_out unchanged.
  - Then set out_ready=1 -> next cycle out_valid=0, in_ready=1, pointer (0,0), data_out still 112233445566.
- Gaps and clear: write 0xA1, idle 3 cycles, write 0xA2 -> pointer (0,2).
  - Then assert clr together with in_valid (data 0xA3) -> data_out=0 and pointer (0,0).
- Slide (macro defined): from window 112233445566, release with slide=1 -> data_out=223300556600, pointer (0,2).
  - Write 0xAA, 0xBB -> out_valid=1 and data_out=2233AA5566BB.
- Slide (macro undefined): same stimulus -> pointer (0,0) and data_out=112233445566; six writes are required before out_valid.
